// File: rtl/pipelined_control_unit.sv
// Registered instruction decoder between fetch and the ID/EX register.
// Decodes ARM-style data-processing, LDR/LDRB/STR/STRB and B/BL words, evaluates
// the condition field against an NZCV register (with same-cycle flag bypass),
// holds fetch off for a fixed number of cycles after a load and honours flush.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// RUN    | instr_ready high, one instruction may be accepted per cycle
// WAIT   | load stall, instr_ready low, down-counter runs to its terminal count
module pipelined_control_unit #(
    parameter int ALU_OP_WIDTH     = 4,
    parameter int LOAD_WAIT_CYCLES = 2,
    parameter int ENABLE_COND      = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    instr_valid,
    output logic                    instr_ready,
    input  logic [31:0]             instruction,
    input  logic [3:0]              flags_in,
    input  logic                    flags_in_valid,
    input  logic                    flush,
    output logic                    ctrl_valid,
    output logic                    reg_write_enable,
    output logic                    mem_read_enable,
    output logic                    mem_write_enable,
    output logic                    mem_to_reg_select,
    output logic                    alu_source_select,
    output logic                    byte_access,
    output logic                    status_bit,
    output logic [ALU_OP_WIDTH-1:0] alu_operation,
    output logic                    pc_source_select,
    output logic                    link_enable,
    output logic                    cond_pass,
    output logic                    illegal,
    output logic [3:0]              flags_q
);

    localparam int CNT_W = (LOAD_WAIT_CYCLES < 1) ? 1 : $clog2(LOAD_WAIT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LOAD_WAIT_CYCLES);
    localparam logic [3:0] OP_ADD = 4'b0100;
    localparam logic [3:0] OP_SUB = 4'b0010;

    typedef enum logic {ST_RUN, ST_WAIT} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             accept;

    logic       f_n, f_z, f_c, f_v;
    logic       cond_true, cond_ok, is_nop, undef, act;
    logic [3:0] op_dec;
    logic       d_rw, d_mr, d_mw, d_m2r, d_as, d_ba, d_sb, d_pc, d_lk, d_cp, d_il, d_stall;

    assign accept = instr_valid & instr_ready;

    // Decode and condition evaluation for the word currently presented.
    always_comb begin
        {f_n, f_z, f_c, f_v} = flags_in_valid ? flags_in : flags_q;
        unique case (instruction[31:28])
            4'h0:    cond_true = f_z;
            4'h1:    cond_true = ~f_z;
            4'h2:    cond_true = f_c;
            4'h3:    cond_true = ~f_c;
            4'h4:    cond_true = f_n;
            4'h5:    cond_true = ~f_n;
            4'h6:    cond_true = f_v;
            4'h7:    cond_true = ~f_v;
            4'h8:    cond_true = f_c & ~f_z;
            4'h9:    cond_true = ~f_c | f_z;
            4'hA:    cond_true = (f_n == f_v);
            4'hB:    cond_true = (f_n != f_v);
            4'hC:    cond_true = ~f_z & (f_n == f_v);
            4'hD:    cond_true = f_z | (f_n != f_v);
            4'hE:    cond_true = 1'b1;
            default: cond_true = 1'b0;
        endcase
        cond_ok = (ENABLE_COND != 0) ? cond_true : 1'b1;
        is_nop  = (instruction == 32'h0);
        undef   = (instruction[27:25] == 3'b100) || (instruction[27:26] == 2'b11);
        d_il    = ~is_nop & ((instruction[31:28] == 4'hF) | undef);
        d_cp    = cond_ok & ~is_nop;
        // Enables only fire for a legal, non-NOP word whose condition holds.
        act     = d_cp & ~d_il;

        op_dec = 4'b0000;
        d_rw = 1'b0; d_mr = 1'b0; d_mw = 1'b0; d_m2r = 1'b0; d_as = 1'b0;
        d_ba = 1'b0; d_sb = 1'b0; d_pc = 1'b0; d_lk = 1'b0; d_stall = 1'b0;

        if (instruction[27:26] == 2'b00) begin
            op_dec = instruction[24:21];
            if (act) begin
                d_as = instruction[25];
                if (instruction[24:23] == 2'b10) begin
                    d_sb = 1'b1;
                end else begin
                    d_sb = instruction[20];
                    d_rw = 1'b1;
                end
            end
        end else if (instruction[27:26] == 2'b01) begin
            op_dec = instruction[23] ? OP_ADD : OP_SUB;
            if (act) begin
                d_as = ~instruction[25];
                d_ba = instruction[22];
                if (instruction[20]) begin
                    d_rw    = 1'b1;
                    d_mr    = 1'b1;
                    d_m2r   = 1'b1;
                    d_stall = (LOAD_WAIT_CYCLES > 0);
                end else begin
                    d_mw = 1'b1;
                end
            end
        end else if (instruction[27:25] == 3'b101) begin
            op_dec = OP_ADD;
            if (act) begin
                d_pc = 1'b1;
                d_lk = instruction[24];
                d_rw = instruction[24];
            end
        end

        if (is_nop) begin
            op_dec = 4'b0000;
        end
    end

    // Next-state and stall counter; flush overrides any transition.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (flush) begin
            state_nxt = ST_RUN;
            cnt_nxt   = '0;
        end else begin
            unique case (state)
                ST_RUN: begin
                    if (accept && d_stall) begin
                        state_nxt = ST_WAIT;
                        cnt_nxt   = CNT_LOAD;
                    end
                end
                ST_WAIT: begin
                    if (cnt <= CNT_W'(1)) begin
                        state_nxt = ST_RUN;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state_nxt = ST_RUN;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // State register; ready is registered so it stays low through reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_RUN;
            cnt         <= '0;
            instr_ready <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            instr_ready <= (state_nxt == ST_RUN);
        end
    end

    // Control bundle register: valid for one cycle after an unflushed accept.
    always_ff @(posedge clk) begin
        if (!rst_n || !(accept && !flush)) begin
            ctrl_valid        <= 1'b0;
            reg_write_enable  <= 1'b0;
            mem_read_enable   <= 1'b0;
            mem_write_enable  <= 1'b0;
            mem_to_reg_select <= 1'b0;
            alu_source_select <= 1'b0;
            byte_access       <= 1'b0;
            status_bit        <= 1'b0;
            alu_operation     <= '0;
            pc_source_select  <= 1'b0;
            link_enable       <= 1'b0;
            cond_pass         <= 1'b0;
            illegal           <= 1'b0;
        end else begin
            ctrl_valid        <= 1'b1;
            reg_write_enable  <= d_rw;
            mem_read_enable   <= d_mr;
            mem_write_enable  <= d_mw;
            mem_to_reg_select <= d_m2r;
            alu_source_select <= d_as;
            byte_access       <= d_ba;
            status_bit        <= d_sb;
            alu_operation     <= ALU_OP_WIDTH'(op_dec);
            pc_source_select  <= d_pc;
            link_enable       <= d_lk;
            cond_pass         <= d_cp;
            illegal           <= d_il;
        end
    end

    // NZCV register, updated independently of flush.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flags_q <= 4'b0000;
        end else if (flags_in_valid) begin
            flags_q <= flags_in;
        end
    end

endmodule
